// File: rtl/pll_lock_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | pll_seq_pkg : shared types for the PLL lock sequencer   (rev 1.0)  |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pll_lock_sequencer_if.sv
// +--------------------------------------------------------------------+
// | pll_lock_sequencer_if : PLL control/status bundle       (rev 1.0)  |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface pll_lock_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               restart_req;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               ready;
  logic               lock_lost;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [STATE_W-1:0] state;

  // master is the sequencer itself; slave is the PLL wrapper / board side
  modport master (
    input  pll_locked, restart_req,
    output pll_rst, sys_rst_n, ready, lock_lost, fault, retry_cnt, state
  );

  modport slave (
    output pll_locked, restart_req,
    input  pll_rst, sys_rst_n, ready, lock_lost, fault, retry_cnt, state
  );

endinterface

`default_nettype wire

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// +--------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for a single async level (rev 1.0)|
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// +--------------------------------------------------------------------+
// | pll_lock_sequencer : PLL reset/lock/settle sequencer    (rev 1.0)  |
// | Optional lock-timeout retry/FAULT logic: PLL_SEQ_TIMEOUT_EN        |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY      = 4,
  parameter int CNT_W          = 17
) (
  input  logic                 refclk_i,
  input  logic                 rst_n_i,
  pll_lock_sequencer_if.master seq_if
);

  // Elaboration-time parameter sanity
  if (RST_CYCLES < 2) begin : g_chk_rst_cycles
    $error("pll_lock_sequencer: RST_CYCLES must be >= 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_chk_settle_cycles
    $error("pll_lock_sequencer: SETTLE_CYCLES must be >= 1");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_chk_max_retry
    $error("pll_lock_sequencer: MAX_RETRY must be in 1..15");
  end
  if (CNT_W < 1 || CNT_W > 30 ||
      (RST_CYCLES - 1)     >= (1 << CNT_W) ||
      (SETTLE_CYCLES - 1)  >= (1 << CNT_W) ||
      (TIMEOUT_CYCLES - 1) >= (1 << CNT_W)) begin : g_chk_cnt_w
    $error("pll_lock_sequencer: CNT_W too narrow for the cycle parameters");
  end

  localparam logic [CNT_W-1:0] c_RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0]   c_WAIT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] c_MAX_RETRY = RETRY_W'(MAX_RETRY);
`else
  localparam logic [CNT_W-1:0]   c_WAIT_LOAD = '0;
`endif

  logic             lock_s;
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             lock_lost_q, lock_lost_d;
  logic             pll_rst_q,   pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q,     ready_d;
`ifdef PLL_SEQ_TIMEOUT_EN
  logic [RETRY_W-1:0] retry_q,   retry_d;
  logic               fault_q,   fault_d;
`endif

  sync_2ff u_lock_sync (
    .clk_i   (refclk_i),
    .rst_n_i (rst_n_i),
    .d_i     (seq_if.pll_locked),
    .q_o     (lock_s)
  );

  always_ff @(posedge refclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= HOLD;
      cnt_q       <= c_RST_LOAD;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_q     <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_q     <= retry_d;
      fault_q     <= fault_d;
`endif
    end
  end

  // The counter is reloaded on every state entry and counts down while resident.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;
`ifdef PLL_SEQ_TIMEOUT_EN
    retry_d     = retry_q;
`endif
    if (seq_if.restart_req) begin
      state_d     = HOLD;
      cnt_d       = c_RST_LOAD;
      lock_lost_d = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_d     = '0;
`endif
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = WAIT_LOCK;
            cnt_d   = c_WAIT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = SETTLE;
            cnt_d   = c_SETTLE_LOAD;
`ifdef PLL_SEQ_TIMEOUT_EN
          end else if (cnt_q == '0) begin
            // retry_q stays below MAX_RETRY here, so the increment never wraps
            if (retry_q + RETRY_W'(1) == c_MAX_RETRY) begin
              state_d = FAULT;
              cnt_d   = '0;
              retry_d = c_MAX_RETRY;
            end else begin
              state_d = HOLD;
              cnt_d   = c_RST_LOAD;
              retry_d = retry_q + RETRY_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
`endif
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = c_WAIT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d     = HOLD;
            cnt_d       = c_RST_LOAD;
            lock_lost_d = 1'b1;
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_d     = '0;
`endif
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = c_RST_LOAD;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change in the cycle the state is entered.
  always_comb begin
    pll_rst_d   = (state_d == HOLD) || (state_d == FAULT);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
`ifdef PLL_SEQ_TIMEOUT_EN
    fault_d     = (state_d == FAULT);
`endif
  end

  assign seq_if.pll_rst   = pll_rst_q;
  assign seq_if.sys_rst_n = sys_rst_n_q;
  assign seq_if.ready     = ready_q;
  assign seq_if.lock_lost = lock_lost_q;
  assign seq_if.state     = state_q;
`ifdef PLL_SEQ_TIMEOUT_EN
  assign seq_if.retry_cnt = retry_q;
  assign seq_if.fault     = fault_q;
`else
  assign seq_if.retry_cnt = '0;
  assign seq_if.fault     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_pll_lock_sequencer : directed bench for pll_lock_sequencer      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic refclk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES     (4),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .MAX_RETRY      (2),
    .CNT_W          (17)
  ) dut (
    .refclk_i (refclk),
    .rst_n_i  (rst_n),
    .seq_if   (bus)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pll_rst"},   32'(bus.pll_rst),   32'd1);
    chk({tag, ".sys_rst_n"}, 32'(bus.sys_rst_n), 32'd0);
    chk({tag, ".ready"},     32'(bus.ready),     32'd0);
    chk({tag, ".lock_lost"}, 32'(bus.lock_lost), 32'd0);
    chk({tag, ".fault"},     32'(bus.fault),     32'd0);
    chk({tag, ".retry_cnt"}, 32'(bus.retry_cnt), 32'd0);
    chk({tag, ".state"},     32'(bus.state),     32'(HOLD));
  endtask

  task automatic cycles_until_ready(input string tag, input int exp);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic cycles_until_ready_low(input string tag, input int exp);
    int n = 0;
    while (bus.ready === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  // Counts consecutive sampled cycles with pll_rst high, including the current one.
  task automatic count_rst_high(input string tag, input int exp);
    int n = 0;
    while (bus.pll_rst === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.pll_locked  = 1'b0;
    bus.restart_req = 1'b0;
    step(3);
    chk_reset_vals("por");

    // Power-up sequence
    rst_n = 1'b1;
    count_rst_high("hold_len_por", 4);
    chk("wait_after_hold", 32'(bus.state), 32'(WAIT_LOCK));
    step(6);
    bus.pll_locked = 1'b1;
    step(2);
    chk("sync_delay_wait", 32'(bus.state), 32'(WAIT_LOCK));
    step(1);
    chk("settle_entry", 32'(bus.state), 32'(SETTLE));
    cycles_until_ready("settle_to_run", 8);
    chk("run_sys_rst_n", 32'(bus.sys_rst_n), 32'd1);
    chk("run_pll_rst",   32'(bus.pll_rst),   32'd0);
    chk("run_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("run_state",     32'(bus.state),     32'(RUN));

    // Lock loss in RUN
    step(3);
    bus.pll_locked = 1'b0;
    cycles_until_ready_low("lockfall_to_ready_low", 3);
    chk("loss_lock_lost", 32'(bus.lock_lost), 32'd1);
    chk("loss_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    chk("loss_state",     32'(bus.state),     32'(HOLD));
    chk("loss_retry",     32'(bus.retry_cnt), 32'd0);
    count_rst_high("hold_len_loss", 4);

    // Two-cycle lock glitch during SETTLE
    bus.pll_locked = 1'b1;
    step(3);
    chk("glitch_settle_entry", 32'(bus.state), 32'(SETTLE));
    step(4);
    bus.pll_locked = 1'b0;
    step(2);
    chk("glitch_still_settle", 32'(bus.state), 32'(SETTLE));
    bus.pll_locked = 1'b1;
    step(1);
    chk("glitch_to_wait", 32'(bus.state), 32'(WAIT_LOCK));
    cycles_until_ready("glitch_resettle", 10);
    chk("lock_lost_sticky", 32'(bus.lock_lost), 32'd1);

    // restart_req coincident with lock_s falling in RUN
    step(2);
    bus.pll_locked = 1'b0;
    step(2);
    chk("pre_restart_ready", 32'(bus.ready), 32'd1);
    bus.restart_req = 1'b1;
    step(1);
    bus.restart_req = 1'b0;
    chk("restart_state",     32'(bus.state),     32'(HOLD));
    chk("restart_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("restart_ready",     32'(bus.ready),     32'd0);
    chk("restart_pll_rst",   32'(bus.pll_rst),   32'd1);

    // Async reset during SETTLE
    bus.pll_locked = 1'b1;
    n = 0;
    while (bus.state !== SETTLE && n < 100) begin
      step();
      n++;
    end
    chk("reach_settle", 32'(n), 32'd5);
    step(2);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    step(2);
    rst_n = 1'b1;
    cycles_until_ready("rerun_after_rst", 13);

`ifdef PLL_SEQ_TIMEOUT_EN
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    step(2);
    rst_n = 1'b1;
    n = 0;
    while (bus.retry_cnt !== 4'd1 && n < 200) begin
      step();
      n++;
    end
    chk("first_timeout",     32'(n),           32'd36);
    chk("retry1_state",      32'(bus.state),   32'(HOLD));
    chk("retry1_fault",      32'(bus.fault),   32'd0);
    chk("retry1_pll_rst",    32'(bus.pll_rst), 32'd1);
    n = 0;
    while (bus.fault !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("second_timeout",    32'(n),             32'd36);
    chk("fault_state",       32'(bus.state),     32'(FAULT));
    chk("fault_pll_rst",     32'(bus.pll_rst),   32'd1);
    chk("fault_retry",       32'(bus.retry_cnt), 32'd2);
    chk("fault_ready",       32'(bus.ready),     32'd0);
    step(10);
    chk("fault_sticky",      32'(bus.state),     32'(FAULT));
    bus.restart_req = 1'b1;
    step(1);
    bus.restart_req = 1'b0;
    chk("fault_exit_state",  32'(bus.state),     32'(HOLD));
    chk("fault_exit_retry",  32'(bus.retry_cnt), 32'd0);
    chk("fault_exit_fault",  32'(bus.fault),     32'd0);
    chk("fault_exit_pllrst", 32'(bus.pll_rst),   32'd1);
`else
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(120);
    chk("no_timeout_state",   32'(bus.state),     32'(WAIT_LOCK));
    chk("no_timeout_fault",   32'(bus.fault),     32'd0);
    chk("no_timeout_retry",   32'(bus.retry_cnt), 32'd0);
    chk("no_timeout_pll_rst", 32'(bus.pll_rst),   32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
